// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding, display codes and BCD helpers for the clock controller
package clock_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SET_HH = 2'd1,
        SET_MM = 2'd2,
        SET_SS = 2'd3
    } state_t;

    localparam logic [1:0] BSEL_HH   = 2'b00;
    localparam logic [1:0] BSEL_MM   = 2'b01;
    localparam logic [1:0] BSEL_SS   = 2'b10;
    localparam logic [1:0] BSEL_NONE = 2'b11;

    localparam logic [7:0] HH_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

    // Two-digit BCD increment that wraps to 00 after max
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        return (v == max)         ? 8'h00 :
               (v[3:0] == 4'h9)   ? {v[7:4] + 4'h1, 4'h0} :
                                    v + 8'h01;
    endfunction

    // Two-digit BCD decrement that wraps to max below 00
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        return (v == 8'h00)       ? max :
               (v[3:0] == 4'h0)   ? {v[7:4] - 4'h1, 4'h9} :
                                    v - 8'h01;
    endfunction

    // Field highlighted on the display for a given state
    function automatic logic [1:0] sel_of(input state_t s);
        return (s == SET_HH) ? BSEL_HH :
               (s == SET_MM) ? BSEL_MM :
               (s == SET_SS) ? BSEL_SS : BSEL_NONE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a raw button, filters bounce and emits a one-cycle press pulse
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a level change only after it has been stable for DB_CYCLES samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Rising edge of the debounced level gives a single-cycle pulse; releases are silent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_d <= level;
            pulse   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: 24-hour BCD time keeper with button-driven set mode and blink control
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int DB_CYCLES = 1_000_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       blink_en,
    output logic [1:0] blink_sel,
    output logic       setting
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic          mode_p;
    logic          inc_p;
    logic          dec_p;
    state_t        state;
    state_t        state_n;
    logic [7:0]    hh_n;
    logic [7:0]    mm_n;
    logic [7:0]    ss_n;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_cnt_n;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_cnt_n;
    logic          phase;
    logic          phase_n;
    logic          tick;
    logic          blink_wrap;
    logic          inc_ok;
    logic          dec_ok;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (.clk(clk), .rst_n(rst_n), .btn(btn_mode), .pulse(mode_p));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc  (.clk(clk), .rst_n(rst_n), .btn(btn_inc),  .pulse(inc_p));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dec  (.clk(clk), .rst_n(rst_n), .btn(btn_dec),  .pulse(dec_p));

    // Next state, time fields, dividers and the registered display controls
    always_comb begin
        inc_ok      = inc_p & ~dec_p & ~mode_p;
        dec_ok      = dec_p & ~inc_p & ~mode_p;
        tick        = tick_cnt == TW'(TICK_DIV - 1);
        blink_wrap  = blink_cnt == BW'(BLINK_DIV - 1);
        tick_cnt_n  = (mode_p | tick) ? '0 : tick_cnt + 1'b1;
        blink_cnt_n = (mode_p | blink_wrap) ? '0 : blink_cnt + 1'b1;
        phase_n     = mode_p ? 1'b0 : phase ^ blink_wrap;
        state_n     = !mode_p           ? state  :
                      (state == RUN)    ? SET_HH :
                      (state == SET_HH) ? SET_MM :
                      (state == SET_MM) ? SET_SS : RUN;
        hh_n        = hh;
        mm_n        = mm;
        ss_n        = ss;
        case (state)
            RUN: begin
                if (tick) begin
                    ss_n = bcd_inc(ss, MS_MAX);
                    if (ss == MS_MAX) begin
                        mm_n = bcd_inc(mm, MS_MAX);
                        if (mm == MS_MAX)
                            hh_n = bcd_inc(hh, HH_MAX);
                    end
                end
            end
            SET_HH:  hh_n = inc_ok ? bcd_inc(hh, HH_MAX) : dec_ok ? bcd_dec(hh, HH_MAX) : hh;
            SET_MM:  mm_n = inc_ok ? bcd_inc(mm, MS_MAX) : dec_ok ? bcd_dec(mm, MS_MAX) : mm;
            SET_SS:  ss_n = (inc_ok | dec_ok) ? 8'h00 : ss;
            default: ;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            tick_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_cnt_n;
            blink_cnt <= blink_cnt_n;
            phase     <= phase_n;
        end
    end

    // Registered outputs so the display bus never sees a combinational path from the buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hh        <= 8'h00;
            mm        <= 8'h00;
            ss        <= 8'h00;
            blink_en  <= 1'b0;
            blink_sel <= BSEL_NONE;
            setting   <= 1'b0;
        end else begin
            hh        <= hh_n;
            mm        <= mm_n;
            ss        <= ss_n;
            blink_en  <= phase_n & (state_n != RUN);
            blink_sel <= sel_of(state_n);
            setting   <= state_n != RUN;
        end
    end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: table-driven and sequence checks of the clock controller with a small scoreboard
module tb_clock_time_ctrl;

    localparam int TICK_DIV  = 10;
    localparam int DB_CYCLES = 4;
    localparam int BLINK_DIV = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       blink_en;
    logic [1:0] blink_sel;
    logic       setting;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      name;
        logic       m;
        logic       i;
        logic       d;
        int         len;
        logic [7:0] eh;
        logic [7:0] em;
        logic [7:0] es;
        logic [1:0] sel;
        logic       set;
    } vec_t;

    typedef struct {
        string       name;
        logic [26:0] v;
    } exp_t;

    exp_t sbq[$];
    vec_t vt[13];

    clock_time_ctrl #(
        .TICK_DIV(TICK_DIV),
        .DB_CYCLES(DB_CYCLES),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
        .btn_dec(btn_dec),
        .hh(hh),
        .mm(mm),
        .ss(ss),
        .blink_en(blink_en),
        .blink_sel(blink_sel),
        .setting(setting)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] snap();
        return {hh, mm, ss, blink_sel, setting};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; holds the chosen buttons for len samples, then waits for the release to settle
    task automatic press(input logic m, input logic i, input logic d, input int len);
        btn_mode = m;
        btn_inc  = i;
        btn_dec  = d;
        repeat (len) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic press_exp(input string name, input logic m, input logic i, input logic d, input int len,
                             input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                             input logic [1:0] sel, input logic set);
        exp_t e;
        e.name = name;
        e.v    = {eh, em, es, sel, set};
        sbq.push_back(e);
        press(m, i, d, len);
        e = sbq.pop_front();
        check(e.name, 32'(snap()), 32'(e.v));
    endtask

    initial begin
        int k;
        int blink_hi;
        vt[0]  = '{"mode_hold",    1'b1, 1'b0, 1'b0, 8, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1};
        vt[1]  = '{"mode_glitch",  1'b1, 1'b0, 1'b0, 3, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1};
        vt[2]  = '{"hh_dec_wrap",  1'b0, 1'b0, 1'b1, 8, 8'h23, 8'h00, 8'h00, 2'b00, 1'b1};
        vt[3]  = '{"hh_inc_wrap",  1'b0, 1'b1, 1'b0, 8, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1};
        vt[4]  = '{"hh_dec",       1'b0, 1'b0, 1'b1, 8, 8'h23, 8'h00, 8'h00, 2'b00, 1'b1};
        vt[5]  = '{"inc_dec_same", 1'b0, 1'b1, 1'b1, 8, 8'h23, 8'h00, 8'h00, 2'b00, 1'b1};
        vt[6]  = '{"mode_inc",     1'b1, 1'b1, 1'b0, 8, 8'h23, 8'h00, 8'h00, 2'b01, 1'b1};
        vt[7]  = '{"mm_dec_wrap",  1'b0, 1'b0, 1'b1, 8, 8'h23, 8'h59, 8'h00, 2'b01, 1'b1};
        vt[8]  = '{"mm_inc_wrap",  1'b0, 1'b1, 1'b0, 8, 8'h23, 8'h00, 8'h00, 2'b01, 1'b1};
        vt[9]  = '{"mm_dec",       1'b0, 1'b0, 1'b1, 8, 8'h23, 8'h59, 8'h00, 2'b01, 1'b1};
        vt[10] = '{"mode_ss",      1'b1, 1'b0, 1'b0, 8, 8'h23, 8'h59, 8'h00, 2'b10, 1'b1};
        vt[11] = '{"ss_inc",       1'b0, 1'b1, 1'b0, 8, 8'h23, 8'h59, 8'h00, 2'b10, 1'b1};
        vt[12] = '{"mode_run",     1'b1, 1'b0, 1'b0, 8, 8'h23, 8'h59, 8'h00, 2'b11, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_fields", 32'(snap()), 32'({24'h000000, 2'b11, 1'b0}));
        check("reset_blink", 32'(blink_en), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++)
            press_exp(vt[i].name, vt[i].m, vt[i].i, vt[i].d, vt[i].len,
                      vt[i].eh, vt[i].em, vt[i].es, vt[i].sel, vt[i].set);

        k = 0;
        blink_hi = 0;
        while (ss != 8'h58 && k < 700) begin
            @(negedge clk);
            k++;
            if (blink_en) blink_hi++;
        end
        check("reach_23_59_58", 32'({hh, mm, ss}), 32'(24'h235958));
        repeat (20) @(negedge clk);
        check("rollover", 32'(snap()), 32'({24'h000000, 2'b11, 1'b0}));
        check("run_blink_zero", 32'(blink_hi), 32'd0);

        k = 0;
        while (ss != 8'h37 && k < 500) begin
            @(negedge clk);
            k++;
        end
        press_exp("freeze_ss37", 1'b1, 1'b0, 1'b0, 8, 8'h00, 8'h00, 8'h37, 2'b00, 1'b1);
        press_exp("to_mm",       1'b1, 1'b0, 1'b0, 8, 8'h00, 8'h00, 8'h37, 2'b01, 1'b1);
        press_exp("to_ss",       1'b1, 1'b0, 1'b0, 8, 8'h00, 8'h00, 8'h37, 2'b10, 1'b1);
        press_exp("ss_clear",    1'b0, 1'b1, 1'b0, 8, 8'h00, 8'h00, 8'h00, 2'b10, 1'b1);

        btn_mode = 1'b1;
        k = 0;
        while (setting && k < 20) begin
            @(negedge clk);
            k++;
        end
        btn_mode = 1'b0;
        check("back_to_run", 32'({blink_sel, setting}), 32'({2'b11, 1'b0}));
        k = 0;
        while (ss == 8'h00 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("first_tick_latency", 32'(k), 32'd10);
        check("first_tick_value", 32'({hh, mm, ss}), 32'(24'h000001));

        press_exp("to_hh_again", 1'b1, 1'b0, 1'b0, 8, 8'h00, 8'h00, 8'h01, 2'b00, 1'b1);

        btn_mode = 1'b1;
        k = 0;
        while (blink_sel != 2'b01 && k < 20) begin
            @(negedge clk);
            k++;
        end
        btn_mode = 1'b0;
        for (int j = 0; j < 9; j++) begin
            check($sformatf("blink_k%0d", j), 32'({blink_sel, blink_en}), 32'({2'b01, 1'((j / 3) % 2)}));
            @(negedge clk);
        end

        press_exp("mm_inc", 1'b0, 1'b1, 1'b0, 8, 8'h00, 8'h01, 8'h01, 2'b01, 1'b1);

        #1 rst_n = 1'b0;
        #1;
        check("async_reset_fields", 32'(snap()), 32'({24'h000000, 2'b11, 1'b0}));
        check("async_reset_blink", 32'(blink_en), 32'd0);

        btn_mode = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (blink_sel != 2'b00 && k < 20) begin
            @(negedge clk);
            k++;
        end
        btn_mode = 1'b0;
        check("held_through_reset", 32'(k >= 7 && k <= 9), 32'd1);
        check("held_through_reset_sel", 32'({blink_sel, setting}), 32'({2'b00, 1'b1}));
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Time-keeping and time-setting controller for the 24-hour digital clock. It takes three raw push-buttons, debounces them, and runs a RUN/SET_HH/SET_MM/SET_SS state machine. It keeps the BCD hours/minutes/seconds counters and generates the `hh`/`mm`/`ss`/`blink_en`/`blink_sel` bus that the seven-segment scan block consumes. It is the producer side of that display interface.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000: clk cycles per 1 s time tick.
- `DB_CYCLES`, 1_000_000: consecutive stable samples needed to accept a button level change (20 ms @ 50 MHz).
- `BLINK_DIV`, 12_500_000: clk cycles per blink-phase toggle (2 Hz square wave).

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `btn_mode`  in  1  raw button, active-high, asynchronous to clk.
- `btn_inc`  in  1  raw button, active-high, asynchronous.
- `btn_dec`  in  1  raw button, active-high, asynchronous.
- `hh`  out  8  hours, BCD 00–23.
- `mm`  out  8  minutes, BCD 00–59.
- `ss`  out  8  seconds, BCD 00–59.
- `blink_en`  out  1  blink phase; 1 = selected field blanked.
- `blink_sel`  out  2  field being edited: 00 HH, 01 MM, 10 SS, 11 none.
- `setting`  out  1  high in any SET_* state.

## Operation
- **Reset values:** hh = mm = ss = 8'h00, state RUN, blink_en 0, blink_sel 2'b11, setting 0, all dividers and debouncers cleared. The debounced level resets to 0.
- **Button path (per button):**
  - Two-flop synchronizer.
  - Counter increments while the synced level differs from the debounced level, and clears when they are equal.
  - When the count reaches DB_CYCLES-1 with the levels still differing, the debounced level flips.
  - A 0→1 flip of the debounced level produces a one-cycle `*_pulse`. Releases produce no pulse.
- **State machine:**
  - A mode pulse advances RUN → SET_HH → SET_MM → SET_SS → RUN.
  - blink_sel follows the state (RUN = 11). setting = (state != RUN).
- **RUN:**
  - The 1 s divider counts 0..TICK_DIV-1. On wrap, ss increments.
  - Carry chain resolves in the same cycle: ss 59→00 carries to mm; mm 59→00 carries to hh; 23:59:59 → 00:00:00.
  - inc/dec pulses are ignored.
- **SET_HH / SET_MM:**
  - Time does not advance.
  - inc pulse: field +1, wrapping HH 23→00, MM 59→00.
  - dec pulse: field −1, wrapping HH 00→23, MM 00→59.
  - No carry into other fields.
- **SET_SS:** an inc or dec pulse sets ss = 00.
- **Simultaneous events:**
  - mode together with inc/dec in the same cycle: the mode pulse is processed and inc/dec is dropped.
  - inc and dec together: both are dropped.
- **Divider reset:** the 1 s divider clears on every mode pulse, so after returning to RUN the first tick comes a full TICK_DIV cycles later.
- **Blink:**
  - The phase register toggles every BLINK_DIV cycles.
  - Phase and its counter clear on every mode pulse, so a newly selected field starts visible.
  - blink_en = phase & setting. blink_en is 0 in RUN.
- **BCD:** arithmetic is done per nibble. Illegal BCD values never appear on the outputs.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- **Press latency:** raw rise at edge 0 → the pulse is high in the cycle after edge DB_CYCLES+2. The field/state update is visible after edge DB_CYCLES+3. The bench tolerates ±1.
- **Tick latency:** ss updates on the clock edge after the divider reaches TICK_DIV-1. The carry-chain result is visible on the same edge.
- **Blink:** blink_en changes at most once per BLINK_DIV cycles, except when forced low on a mode pulse.
- **Reset mid-press or mid-edit:** returns to the reset values asynchronously. A button still held at release of reset needs a full DB_CYCLES to register and then generates a pulse.

## Structure
- **Package `clock_pkg`:**
  - `state_t` enum: RUN, SET_HH, SET_MM, SET_SS.
  - Blink_sel codes: BSEL_HH = 2'b00, BSEL_MM = 2'b01, BSEL_SS = 2'b10, BSEL_NONE = 2'b11.
  - BCD limits: HH_MAX 8'h23, MS_MAX 8'h59.
- **Sub-module `btn_debounce`:** synchronizer, debounce counter and rise pulse, parameter DB_CYCLES. Instantiated three times.

## Test plan
Bench parameters: TICK_DIV = 10, DB_CYCLES = 4, BLINK_DIV = 3.
1. **Reset and rollover:** reset, then preload 23:59:58 via the set mode and return to RUN → after 20 cycles the outputs read 00:00:00.
2. **Debounce:** a raw glitch of 3 cycles high on btn_mode → no state change. A hold of 8 cycles → exactly one transition to SET_HH; blink_sel = 00, setting = 1.
3. **Wrap in set mode:**
   - In SET_HH at 00, one dec → hh = 8'h23.
   - In SET_MM at 59, one inc → mm = 8'h00 with hh unchanged.
4. **SET_SS clear:** in SET_SS with ss = 8'h37, an inc → ss = 8'h00. A mode press then → RUN, and the first tick arrives 10 cycles later.
5. **Simultaneous presses:**
   - btn_inc and btn_dec pressed on the same edge → field unchanged.
   - mode and inc together → state advances, no field change.
6. **Blink:**
   - In SET_MM, blink_en toggles every 3 cycles and is 0 right after the mode pulse.
   - In RUN, blink_en stays 0.
   - Asserting rst_n low mid-edit → all outputs return to their reset values within the same cycle.
